// File: rtl/io_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, FSM state encodings and the reset divisor.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit per frame).
package io_uart_pkg;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_BAUDDIV = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;

  localparam logic [15:0] BAUD_RESET = 16'd434;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_STOP   = 3'd3
`ifdef UART_PARITY_EN
    ,
    TX_PARITY = 3'd4
`endif
  } txState_t;

  // A programmed divisor of zero still has to produce a usable bit period.
  function automatic logic [15:0] effDivisor(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/io_uart_fifo.sv
// Small synchronous FIFO holding bytes waiting for transmission.
// A push while full is dropped; full is judged before any same-cycle pop.
module io_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wrData,
  output logic [WIDTH-1:0]             rdData,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  // Storage array: only written on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= wrData;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped UART transmitter: register file, 4-byte TX FIFO and a
// bit-serial TX state machine with a programmable divisor.
// Optional feature macro: UART_PARITY_EN (8E1 frame instead of 8N1).
module io_uart
  import io_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ioCe,
  input  logic        ioWe,
  input  logic [31:0] ioAddr,
  input  logic [31:0] ioWtData,
  output logic [31:0] ioRdData,
  output logic        txd,
  output logic        irq
);

  logic        wrEn;
  logic [1:0]  regSel;
  logic        pushReq;
  logic        popReq;
  logic [7:0]  fifoRdData;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [2:0]  fifoCount;
  logic [15:0] divReg;
  logic        ie;
  logic        overflow;
  txState_t    state;
  txState_t    stateNext;
  logic [15:0] cnt;
  logic [15:0] cntNext;
  logic [2:0]  idx;
  logic [2:0]  idxNext;
  logic [7:0]  shift;
  logic [7:0]  shiftNext;
  logic        txdNext;
  logic        bitDone;
  logic [15:0] reload;
  logic        unusedBits;

  assign wrEn       = ioCe && ioWe;
  assign regSel     = ioAddr[3:2];
  assign pushReq    = wrEn && (regSel == ADDR_TXDATA);
  assign bitDone    = (cnt == 16'd0);
  assign reload     = effDivisor(divReg) - 16'd1;
  assign irq        = ie && fifoEmpty && (state == TX_IDLE);
  assign unusedBits = ^{ioAddr[31:4], ioAddr[1:0], ioWtData[31:16]};

  io_uart_fifo #(
    .DEPTH (4),
    .WIDTH (8)
  ) txFifo (
    .clk    (clk),
    .rst    (rst),
    .push   (pushReq),
    .pop    (popReq),
    .wrData (ioWtData[7:0]),
    .rdData (fifoRdData),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  // Control registers; overflow is sticky until software writes STATUS bit 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divReg   <= BAUD_RESET;
      ie       <= 1'b0;
      overflow <= 1'b0;
    end else if (wrEn) begin
      case (regSel)
        ADDR_TXDATA:  if (fifoFull) overflow <= 1'b1;
        ADDR_STATUS:  if (ioWtData[3]) overflow <= 1'b0;
        ADDR_BAUDDIV: divReg <= ioWtData[15:0];
        default:      ie <= ioWtData[0];
      endcase
    end
  end

  // Combinational read mux; anything not a read access returns zero.
  always_comb begin
    ioRdData = '0;
    if (ioCe && !ioWe) begin
      case (regSel)
        ADDR_STATUS: begin
          ioRdData[STAT_FULL]               = fifoFull;
          ioRdData[STAT_EMPTY]              = fifoEmpty;
          ioRdData[STAT_BUSY]               = (state != TX_IDLE);
          ioRdData[STAT_OVF]                = overflow;
          ioRdData[STAT_COUNT_LSB +: 3]     = fifoCount;
        end
        ADDR_BAUDDIV: ioRdData[15:0] = divReg;
        ADDR_CTRL:    ioRdData[0]    = ie;
        default:      ioRdData       = '0;
      endcase
    end
  end

  // TX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TX_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and datapath updates; the divisor is only sampled at a bit
  // boundary through reload, so a divisor write never stretches a live bit.
  always_comb begin
    stateNext = state;
    popReq    = 1'b0;
    txdNext   = txd;
    cntNext   = cnt;
    idxNext   = idx;
    shiftNext = shift;
    case (state)
      TX_IDLE: begin
        txdNext = 1'b1;
        if (!fifoEmpty) begin
          popReq    = 1'b1;
          shiftNext = fifoRdData;
          stateNext = TX_START;
          txdNext   = 1'b0;
          cntNext   = reload;
        end
      end
      TX_START: begin
        if (bitDone) begin
          stateNext = TX_DATA;
          idxNext   = 3'd0;
          txdNext   = shift[0];
          cntNext   = reload;
        end else begin
          cntNext = cnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (bitDone) begin
          cntNext = reload;
          if (idx == 3'd7) begin
`ifdef UART_PARITY_EN
            stateNext = TX_PARITY;
            txdNext   = ^shift;
`else
            stateNext = TX_STOP;
            txdNext   = 1'b1;
`endif
          end else begin
            idxNext = idx + 3'd1;
            txdNext = shift[idx + 3'd1];
          end
        end else begin
          cntNext = cnt - 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (bitDone) begin
          stateNext = TX_STOP;
          txdNext   = 1'b1;
          cntNext   = reload;
        end else begin
          cntNext = cnt - 16'd1;
        end
      end
`endif
      TX_STOP: begin
        if (bitDone) begin
          if (!fifoEmpty) begin
            popReq    = 1'b1;
            shiftNext = fifoRdData;
            stateNext = TX_START;
            txdNext   = 1'b0;
            cntNext   = reload;
          end else begin
            stateNext = TX_IDLE;
            txdNext   = 1'b1;
          end
        end else begin
          cntNext = cnt - 16'd1;
        end
      end
      default: begin
        stateNext = TX_IDLE;
        txdNext   = 1'b1;
      end
    endcase
  end

  // Datapath registers; txd is a flop so reset forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd   <= 1'b1;
      cnt   <= 16'd0;
      idx   <= 3'd0;
      shift <= 8'd0;
    end else begin
      txd   <= txdNext;
      cnt   <= cntNext;
      idx   <= idxNext;
      shift <= shiftNext;
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart: directed scenarios plus randomized
// traffic compared against a frame-level behavioural model.
// Honours UART_PARITY_EN the same way as the design.
module tb_io_uart;

  localparam logic [31:0] A_TX = 32'h0;
  localparam logic [31:0] A_ST = 32'h4;
  localparam logic [31:0] A_BD = 32'h8;
  localparam logic [31:0] A_CT = 32'hC;

  logic        clk;
  logic        rst;
  logic        ioCe;
  logic        ioWe;
  logic [31:0] ioAddr;
  logic [31:0] ioWtData;
  logic [31:0] ioRdData;
  logic        txd;
  logic        irq;

  int testsRun;
  int testsFailed;
  int waveErrs;
  int irqErrs;

  logic [7:0]  mFifo[$];
  bit          mLevels[$];
  bit          mLevel;
  int          mRemain;
  logic [15:0] mDiv;
  bit          mIe;
  bit          mOvf;

  io_uart dut (
    .clk      (clk),
    .rst      (rst),
    .ioCe     (ioCe),
    .ioWe     (ioWe),
    .ioAddr   (ioAddr),
    .ioWtData (ioWtData),
    .ioRdData (ioRdData),
    .txd      (txd),
    .irq      (irq)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mFifo   = {};
    mLevels = {};
    mLevel  = 1'b1;
    mRemain = 0;
    mDiv    = 16'd434;
    mIe     = 1'b0;
    mOvf    = 1'b0;
  endtask

  function automatic bit modelIrq();
    return mIe && (mFifo.size() == 0) && (mRemain == 0);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    logic [31:0] v;
    v = 32'h0;
    case (addr[3:2])
      2'd1: begin
        v[0]   = (mFifo.size() == 4);
        v[1]   = (mFifo.size() == 0);
        v[2]   = (mRemain > 0);
        v[3]   = mOvf;
        v[6:4] = 3'(mFifo.size());
      end
      2'd2: v[15:0] = mDiv;
      2'd3: v[0]    = mIe;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  // One clock edge of the reference: the line is a list of levels, each held
  // for the divisor in force when that level begins.
  task automatic modelStep(input bit we, input logic [31:0] addr, input logic [31:0] data);
    int occ;
    int eff;
    logic [7:0] b;
    occ = mFifo.size();
    eff = (mDiv == 16'd0) ? 1 : int'(mDiv);
    if (mRemain > 1) begin
      mRemain--;
    end else if (mLevels.size() > 0) begin
      mLevel  = mLevels.pop_front();
      mRemain = eff;
    end else if (occ > 0) begin
      b = mFifo.pop_front();
      mLevels = {};
      for (int k = 0; k < 8; k++) mLevels.push_back(b[k]);
`ifdef UART_PARITY_EN
      mLevels.push_back(^b);
`endif
      mLevels.push_back(1'b1);
      mLevel  = 1'b0;
      mRemain = eff;
    end else begin
      mLevel  = 1'b1;
      mRemain = 0;
    end
    if (we) begin
      case (addr[3:2])
        2'd0: if (occ == 4) mOvf = 1'b1; else mFifo.push_back(data[7:0]);
        2'd1: if (data[3]) mOvf = 1'b0;
        2'd2: mDiv = data[15:0];
        default: mIe = data[0];
      endcase
    end
  endtask

  // Drive one bus cycle; the line and irq seen at this negedge are compared
  // with the model state after the previous edge.
  task automatic applyStimulus(input bit ce, input bit we, input logic [31:0] addr,
                               input logic [31:0] data, input string tag);
    @(negedge clk);
    if (txd !== mLevel) waveErrs++;
    if (irq !== modelIrq()) irqErrs++;
    ioCe     = ce;
    ioWe     = we;
    ioAddr   = addr;
    ioWtData = data;
    #1;
    if (ce && !we) checkOutput(tag, ioRdData, modelRead(addr));
    else if (!ce && tag != "") checkOutput(tag, ioRdData, 32'h0);
    modelStep(ce && we, addr, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, "");
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, data, "");
  endtask

  task automatic readReg(input logic [31:0] addr, input string tag);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && (mRemain > 0 || mFifo.size() > 0); i++) idle(1);
    idle(3);
  endtask

  task automatic checkWave(input string tag);
    checkOutput({tag, "_txd_wave_errs"}, waveErrs, 0);
    checkOutput({tag, "_irq_errs"}, irqErrs, 0);
    waveErrs = 0;
    irqErrs  = 0;
  endtask

  initial begin
    logic [7:0] b;
    int n;
    testsRun = 0;
    testsFailed = 0;
    waveErrs = 0;
    irqErrs = 0;
    rst = 1'b1;
    ioCe = 1'b0;
    ioWe = 1'b0;
    ioAddr = 32'h0;
    ioWtData = 32'h0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_irq", irq, 0);
    readReg(A_ST, "reset_status");
    checkOutput("reset_status_const", ioRdData, 32'h2);
    readReg(A_BD, "reset_bauddiv");
    checkOutput("reset_bauddiv_const", ioRdData, 32'd434);
    readReg(A_CT, "reset_ctrl");
    readReg(A_TX, "txdata_reads_zero");

    // Single 0x55 frame at divisor 4 with interrupts enabled.
    writeReg(A_CT, 32'h1);
    writeReg(A_BD, 32'd4);
    writeReg(A_TX, 32'h55);
    readReg(A_ST, "push_visible_status");
    drain();
    checkWave("frame55");
    checkOutput("irq_after_drain", irq, 1);

    // Overflow: fill the FIFO while a frame is in flight, then clear.
    writeReg(A_CT, 32'h0);
    writeReg(A_BD, 32'd2);
    writeReg(A_TX, 32'h11);
    idle(3);
    for (int i = 0; i < 5; i++) writeReg(A_TX, 32'h20 + i);
    readReg(A_ST, "overflow_status");
    checkOutput("overflow_status_const", ioRdData, 32'h4D);
    drain();
    writeReg(A_ST, 32'h8);
    readReg(A_ST, "overflow_cleared");
    checkWave("overflow_frames");

    // Divisor change in the middle of a data bit.
    writeReg(A_BD, 32'd4);
    writeReg(A_TX, 32'hA5);
    idle(10);
    writeReg(A_BD, 32'd8);
    drain();
    checkWave("div_change");

    // Divisor zero acts as one; reads with ioCe low return zero.
    writeReg(A_BD, 32'd0);
    readReg(A_BD, "bauddiv_zero");
    writeReg(A_TX, 32'h3C);
    drain();
    checkWave("div_zero");
    applyStimulus(1'b0, 1'b0, A_ST, 32'h0, "ce_low_read");

`ifdef UART_PARITY_EN
    // Even parity bit: 0x07 carries 1, 0x03 carries 0.
    writeReg(A_BD, 32'd2);
    writeReg(A_TX, 32'h07);
    writeReg(A_TX, 32'h03);
    drain();
    checkWave("parity");
`endif

    // Randomized traffic.
    for (int it = 0; it < 8; it++) begin
      writeReg(A_CT, 32'($urandom_range(0, 1)));
      writeReg(A_BD, 32'($urandom_range(0, 5)));
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        writeReg(A_TX, {24'($urandom), b});
        idle($urandom_range(0, 3));
        readReg(A_ST, "rand_status_mid");
      end
      drain();
      readReg(A_ST, "rand_status_end");
      writeReg(A_ST, 32'h8);
      checkWave("rand");
    end

    // Reset in the middle of data bit 3 of a 0x00 frame.
    writeReg(A_BD, 32'd4);
    writeReg(A_TX, 32'h00);
    idle(18);
    @(negedge clk);
    checkOutput("pre_reset_txd", txd, 0);
    #2 rst = 1'b1;
    #1 checkOutput("reset_async_txd", txd, 1);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    readReg(A_ST, "post_reset_status");
    checkOutput("post_reset_status_const", ioRdData, 32'h2);
    readReg(A_BD, "post_reset_bauddiv");
    idle(60);
    checkWave("post_reset_no_frame");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
